pipeline_hazard_ctl: RTL and testbench
======================================

Name: pipeline_hazard_ctl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use RAW hazards between ID and EX.
- Flushes younger stages on a taken branch resolved in MEM.
- Freezes the whole pipeline while the data-memory access in MEM is not ready, with a timeout watchdog.
- Drives write-enables/flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..3; 3 = no-forwarding configuration)
TIMEOUT_CYCLES, 255, MEM_WAIT cycles before error; 0 disables watchdog
CNT_W, 32, perf counter width (used only with optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  instruction in EX is a load
ex_rd  in  5  destination reg of instruction in EX
mem_pcsrc  in  1  taken branch resolved in MEM this cycle
dmem_req  in  1  MEM stage performing data access
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID cleared to NOP
id_ex_bubble  out  1  ID/EX controls zeroed (bubble)
ex_mem_flush  out  1  EX/MEM controls zeroed
pipe_hold  out  1  ID/EX, EX/MEM, MEM/WB hold value
ctl_state  out  2  current state (RUN=0, LOAD_STALL=1, MEM_WAIT=2, ERROR=3)
timeout_err  out  1  sticky watchdog error

Behaviour:
- Outputs are combinational from registered state plus current inputs (Mealy). State and counters are registered.
- Default outputs (no event): pc_write=1, if_id_write=1, all flush/bubble/hold=0.
- Reset (reset=0, async):
  - state=RUN; stall_cnt, wait_cnt, ret_state, ret_cnt = 0; timeout_err=0.
  - While reset is asserted, all outputs are forced to 0.
- Hazard condition (hz): ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Freeze outputs: pc_write=0, if_id_write=0, pipe_hold=1, flush/bubble=0.
- Event priority per cycle: memory wait > branch flush > load-use.
- RUN:
  - dmem_req & !dmem_ready: freeze; ret_state=RUN; wait_cnt=1; go MEM_WAIT.
  - else mem_pcsrc: pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; stay RUN.
  - else hz: pc_write=0, if_id_write=0, id_ex_bubble=1; if LOAD_USE_STALLS>1 then stall_cnt=LOAD_USE_STALLS-1, go LOAD_STALL.
- LOAD_STALL:
  - dmem_req & !dmem_ready: freeze; ret_state=LOAD_STALL; stall_cnt preserved; go MEM_WAIT.
  - else mem_pcsrc: branch flush as in RUN; stall aborted; go RUN.
  - else: pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt--; at 1->0 go RUN.
- MEM_WAIT:
  - !dmem_ready: freeze; wait_cnt++ (saturating).
  - If TIMEOUT_CYCLES!=0 and wait_cnt==TIMEOUT_CYCLES: go ERROR; timeout_err=1 from the next cycle.
  - dmem_ready: freeze released this cycle. Evaluate mem_pcsrc/hz/LOAD_STALL rules as in ret_state, then go to the resulting state. wait_cnt=0.
  - mem_pcsrc asserted during a frozen cycle is ignored (the branch is held in EX/MEM and re-presented).
- ERROR: freeze permanently; timeout_err=1; exits only via reset.
- Reset mid-operation: state abandoned immediately; no pending stall or flush survives.
- ex_rd==0 never stalls (x0).
- dmem_ready without dmem_req: ignored in RUN and LOAD_STALL.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles, flush_count, wait_cycles (CNT_W each, reset 0, wrap on overflow).
  - stall_cycles increments on each load-use bubble cycle.
  - flush_count increments on each branch flush.
  - wait_cycles increments on each frozen cycle.
- Undefined: the ports and counter logic are absent.

Decomposition:
- Package pipe_ctl_pkg: state enum (RUN/LOAD_STALL/MEM_WAIT/ERROR, 2-bit encoding), REG_ADDR_W=5, priority constants.
- Sub-module hazard_compare (combinational hz detection) is natural and reusable by a future forwarding unit.

Test Plan:
- Load x5 in EX (ex_memread=1, ex_rd=5), ID reads rs2=5, LOAD_USE_STALLS=1 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle defaults.
- Same with ex_rd=0 -> no stall.
- LOAD_USE_STALLS=3 -> 3 bubble cycles, ctl_state=1 for 2 cycles.
- mem_pcsrc=1 during LOAD_STALL -> all three flushes plus pc_write=1 that cycle; state RUN.
- dmem_req=1, dmem_ready=0 for 4 cycles then 1 -> pipe_hold=1 for 4 cycles, ctl_state=2; released on the ready cycle.
- MEM_WAIT started from LOAD_STALL -> remaining bubbles resume after ready.
- TIMEOUT_CYCLES=8, dmem_ready held 0 -> ctl_state=3 and timeout_err=1 after 8 wait cycles; freeze persists; reset=0 pulse mid-ERROR -> state 0, timeout_err 0 immediately.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 flush + 3 wait cycles -> stall_cycles=2, flush_count=1, wait_cycles=3.

Source files
------------

// File: rtl/pipeline_hazard_ctl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// per-cycle event codes (ordered by priority) and register-match helper.
package pipe_ctl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_ERROR      = 2'd3
    } ctl_state_e;

    // Numerically larger event wins when several are pending in one cycle
    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_LOAD_USE = 2'd1,
        EV_BRANCH   = 2'd2,
        EV_MEM_WAIT = 2'd3
    } ctl_event_e;

    function automatic logic reg_match(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return uses & (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctl_hazard_compare.sv
// Combinational load-use RAW detector between ID and EX; x0 never hazards.
// Kept standalone so a forwarding unit can reuse the same compare.
module hazard_compare
    import pipe_ctl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hz
);

    assign hz = ex_memread
              & (ex_rd != {REG_ADDR_W{1'b0}})
              & (reg_match(id_uses_rs1, id_rs1, ex_rd) | reg_match(id_uses_rs2, id_rs2, ex_rd));

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Stall/flush sequencer for the 5-stage pipeline (Mealy outputs, registered state).
// Optional HAZARD_PERF_CNT_EN adds stall/flush/wait performance counters.
module pipeline_hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int CNT_W           = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_pcsrc,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_flush,
    output logic                  pipe_hold,
    output logic [1:0]            ctl_state,
    output logic                  timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [CNT_W-1:0]      wait_cycles
`endif
);

    localparam logic [1:0]            STALL_INIT = 2'(LOAD_USE_STALLS - 1);
    localparam bit                    WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_CNT_W-1:0] WDOG_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = {WAIT_CNT_W{1'b1}};

    if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 3 || CNT_W < 1) begin : g_bad_cfg
        $error("pipeline_hazard_ctl: unsupported parameter set");
    end

    ctl_state_e            state_r, nxt_state_s;
    ctl_state_e            ret_state_r, nxt_ret_state_s;
    ctl_state_e            eval_state_s;
    ctl_event_e            ev_s;
    logic [1:0]            stall_cnt_r, nxt_stall_cnt_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r, nxt_wait_cnt_s;
    logic                  timeout_err_r, nxt_timeout_err_s;
    logic                  hz_s;
    logic                  active_s;
    logic                  freeze_s;
    logic                  flush_s;
    logic                  lu_bubble_s;

    hazard_compare u_hazard_compare (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .hz          (hz_s)
    );

    // Pick the highest-priority event; a released MEM_WAIT replays its return state's rules
    always_comb begin
        ev_s         = EV_NONE;
        active_s     = 1'b0;
        eval_state_s = state_r;
        case (state_r)
            ST_MEM_WAIT: begin
                eval_state_s = ret_state_r;
                active_s     = dmem_ready;
            end
            ST_ERROR: begin
                active_s = 1'b0;
            end
            default: begin
                active_s = 1'b1;
            end
        endcase
        if (!active_s) begin
            ev_s = EV_NONE;
        end else if (dmem_req && !dmem_ready) begin
            ev_s = EV_MEM_WAIT;
        end else if (mem_pcsrc) begin
            ev_s = EV_BRANCH;
        end else if ((eval_state_s == ST_LOAD_STALL) || hz_s) begin
            ev_s = EV_LOAD_USE;
        end else begin
            ev_s = EV_NONE;
        end
    end

    // Next-state, counters and raw control strobes for the selected event
    always_comb begin
        nxt_state_s       = state_r;
        nxt_ret_state_s   = ret_state_r;
        nxt_stall_cnt_s   = stall_cnt_r;
        nxt_wait_cnt_s    = wait_cnt_r;
        nxt_timeout_err_s = timeout_err_r;
        freeze_s          = 1'b0;
        flush_s           = 1'b0;
        lu_bubble_s       = 1'b0;
        case (ev_s)
            EV_MEM_WAIT: begin
                freeze_s        = 1'b1;
                nxt_state_s     = ST_MEM_WAIT;
                nxt_ret_state_s = eval_state_s;
                nxt_wait_cnt_s  = WAIT_CNT_W'(1);
            end
            EV_BRANCH: begin
                flush_s         = 1'b1;
                nxt_state_s     = ST_RUN;
                nxt_stall_cnt_s = 2'd0;
                nxt_wait_cnt_s  = {WAIT_CNT_W{1'b0}};
            end
            EV_LOAD_USE: begin
                lu_bubble_s    = 1'b1;
                nxt_wait_cnt_s = {WAIT_CNT_W{1'b0}};
                if (eval_state_s == ST_LOAD_STALL) begin
                    nxt_stall_cnt_s = stall_cnt_r - 2'd1;
                    nxt_state_s     = (stall_cnt_r == 2'd1) ? ST_RUN : ST_LOAD_STALL;
                end else if (LOAD_USE_STALLS > 1) begin
                    nxt_stall_cnt_s = STALL_INIT;
                    nxt_state_s     = ST_LOAD_STALL;
                end else begin
                    nxt_state_s = ST_RUN;
                end
            end
            default: begin
                if (state_r == ST_ERROR) begin
                    freeze_s          = 1'b1;
                    nxt_timeout_err_s = 1'b1;
                end else if (state_r == ST_MEM_WAIT && !dmem_ready) begin
                    // Branch requests are ignored here; EX/MEM holds and re-presents them
                    freeze_s = 1'b1;
                    if (WDOG_EN && (wait_cnt_r == WDOG_LIMIT)) begin
                        nxt_state_s       = ST_ERROR;
                        nxt_timeout_err_s = 1'b1;
                    end else if (wait_cnt_r != WAIT_MAX) begin
                        nxt_wait_cnt_s = wait_cnt_r + WAIT_CNT_W'(1);
                    end else begin
                        nxt_wait_cnt_s = wait_cnt_r;
                    end
                end else begin
                    nxt_state_s    = ST_RUN;
                    nxt_wait_cnt_s = {WAIT_CNT_W{1'b0}};
                end
            end
        endcase
    end

    // Sequencer state and counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            ret_state_r   <= ST_RUN;
            stall_cnt_r   <= 2'd0;
            wait_cnt_r    <= {WAIT_CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= nxt_state_s;
            ret_state_r   <= nxt_ret_state_s;
            stall_cnt_r   <= nxt_stall_cnt_s;
            wait_cnt_r    <= nxt_wait_cnt_s;
            timeout_err_r <= nxt_timeout_err_s;
        end
    end

    // All controls read 0 while reset is held, so nothing leaks out of an abandoned state
    assign pc_write     = reset & ~freeze_s & ~lu_bubble_s;
    assign if_id_write  = reset & ~freeze_s & ~lu_bubble_s;
    assign if_id_flush  = reset & flush_s;
    assign id_ex_bubble = reset & (flush_s | lu_bubble_s);
    assign ex_mem_flush = reset & flush_s;
    assign pipe_hold    = reset & freeze_s;
    assign ctl_state    = reset ? state_r : ST_RUN;
    assign timeout_err  = reset & timeout_err_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_count_r;
    logic [CNT_W-1:0] wait_cycles_r;

    // Wrapping performance counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_count_r  <= {CNT_W{1'b0}};
            wait_cycles_r  <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(lu_bubble_s);
            flush_count_r  <= flush_count_r + CNT_W'(flush_s);
            wait_cycles_r  <= wait_cycles_r + CNT_W'(freeze_s);
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
    assign wait_cycles  = wait_cycles_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed bench for pipeline_hazard_ctl: one instance with 1 load-use bubble,
// one with 3, both with an 8-cycle watchdog, driven by the same stimulus.
module tb_pipeline_hazard_ctl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memread, mem_pcsrc, dmem_req, dmem_ready;

    logic       pcw1, ifw1, iff1, bub1, exf1, hold1, te1;
    logic [1:0] st1;
    logic       pcw3, ifw3, iff3, bub3, exf3, hold3, te3;
    logic [1:0] st3;
    logic [8:0] out1, out3;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected-output field order: pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_hold
    localparam logic [5:0] K_DEF = 6'b110000;
    localparam logic [5:0] K_BUB = 6'b000100;
    localparam logic [5:0] K_FLS = 6'b111110;
    localparam logic [5:0] K_FRZ = 6'b000001;
    localparam logic [8:0] OFF   = 9'd0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fc1, wc1, sc3, fc3, wc3;
`endif

    always #5 clock = ~clock;

    pipeline_hazard_ctl #(.LOAD_USE_STALLS(1), .TIMEOUT_CYCLES(8), .CNT_W(32)) u_dut1 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_pcsrc(mem_pcsrc),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(iff1), .id_ex_bubble(bub1),
        .ex_mem_flush(exf1), .pipe_hold(hold1), .ctl_state(st1), .timeout_err(te1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .flush_count(fc1), .wait_cycles(wc1)
`endif
    );

    pipeline_hazard_ctl #(.LOAD_USE_STALLS(3), .TIMEOUT_CYCLES(8), .CNT_W(32)) u_dut3 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_pcsrc(mem_pcsrc),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pcw3), .if_id_write(ifw3), .if_id_flush(iff3), .id_ex_bubble(bub3),
        .ex_mem_flush(exf3), .pipe_hold(hold3), .ctl_state(st3), .timeout_err(te3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc3), .flush_count(fc3), .wait_cycles(wc3)
`endif
    );

    assign out1 = {pcw1, ifw1, iff1, bub1, exf1, hold1, st1, te1};
    assign out3 = {pcw3, ifw3, iff3, bub3, exf3, hold3, st3, te3};

    function automatic logic [8:0] ex(input logic [5:0] k, input logic [1:0] st, input logic te);
        return {k, st, te};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic mr, input logic [4:0] rd, input logic pcsrc,
                          input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_memread = mr; ex_rd = rd; mem_pcsrc = pcsrc; dmem_req = req; dmem_ready = rdy;
    endtask

    // Inputs are already applied; check mid-cycle, then advance past the next rising edge
    task automatic cyc(input string tag, input logic [8:0] e1, input logic [8:0] e3);
        @(negedge clock);
        check_eq({tag, "/lus1"}, {23'd0, out1}, {23'd0, e1});
        check_eq({tag, "/lus3"}, {23'd0, out3}, {23'd0, e3});
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        #1;
        cyc("rst", OFF, OFF);
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("idle", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // load x5 in EX, ID reads rs2=x5
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("lu_a", ex(K_BUB, 2'd0, 1'b0), ex(K_BUB, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("lu_b", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        cyc("lu_c", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        cyc("lu_d", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // x0 destination and unused-source match never stall
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("x0", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));
        set_in(5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cyc("nouse", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // rs1 hazard, then a taken branch during LOAD_STALL
        set_in(5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs1", ex(K_BUB, 2'd0, 1'b0), ex(K_BUB, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("br_ls", ex(K_FLS, 2'd0, 1'b0), ex(K_FLS, 2'd1, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("rdy_noreq", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // branch beats load-use
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("br_hz", ex(K_FLS, 2'd0, 1'b0), ex(K_FLS, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("br_hz2", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // 4-cycle memory wait; branch during freeze ignored
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mw_0", ex(K_FRZ, 2'd0, 1'b0), ex(K_FRZ, 2'd0, 1'b0));
        cyc("mw_1", ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        mem_pcsrc = 1'b1;
        cyc("mw_2", ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        mem_pcsrc = 1'b0;
        cyc("mw_3", ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        dmem_ready = 1'b1;
        cyc("mw_rel", ex(K_DEF, 2'd2, 1'b0), ex(K_DEF, 2'd2, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("mw_after", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // memory wait beats branch and hazard; on release branch beats hazard
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        cyc("pr_frz", ex(K_FRZ, 2'd0, 1'b0), ex(K_FRZ, 2'd0, 1'b0));
        dmem_ready = 1'b1;
        cyc("pr_br", ex(K_FLS, 2'd2, 1'b0), ex(K_FLS, 2'd2, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("pr_after", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // memory wait entered from LOAD_STALL resumes the remaining bubbles
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("ls_hz", ex(K_BUB, 2'd0, 1'b0), ex(K_BUB, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("ls_frz", ex(K_FRZ, 2'd0, 1'b0), ex(K_FRZ, 2'd1, 1'b0));
        cyc("ls_wait", ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        dmem_ready = 1'b1;
        cyc("ls_rel", ex(K_DEF, 2'd2, 1'b0), ex(K_BUB, 2'd2, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("ls_res", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        cyc("ls_done", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        // watchdog: ERROR once the wait count reaches 8
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("to_0", ex(K_FRZ, 2'd0, 1'b0), ex(K_FRZ, 2'd0, 1'b0));
        for (int i = 1; i <= 8; i++) begin
            cyc($sformatf("to_w%0d", i), ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("to_err0", ex(K_FRZ, 2'd3, 1'b1), ex(K_FRZ, 2'd3, 1'b1));
        cyc("to_err1", ex(K_FRZ, 2'd3, 1'b1), ex(K_FRZ, 2'd3, 1'b1));

        // reset pulse in ERROR clears everything without waiting for a clock
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("to_rst/lus1", {23'd0, out1}, {23'd0, OFF});
        check_eq("to_rst/lus3", {23'd0, out3}, {23'd0, OFF});
        #1;
        reset = 1'b1;
        #1;
        check_eq("to_clr/lus1", {23'd0, out1}, {23'd0, ex(K_DEF, 2'd0, 1'b0)});
        check_eq("to_clr/lus3", {23'd0, out3}, {23'd0, ex(K_DEF, 2'd0, 1'b0)});
        @(posedge clock);
        #1;

        // two load-use hazards, one branch, three frozen cycles
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("p_hz0", ex(K_BUB, 2'd0, 1'b0), ex(K_BUB, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("p_i0", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        cyc("p_i1", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        set_in(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        cyc("p_hz1", ex(K_BUB, 2'd0, 1'b0), ex(K_BUB, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("p_i2", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        cyc("p_i3", ex(K_DEF, 2'd0, 1'b0), ex(K_BUB, 2'd1, 1'b0));
        mem_pcsrc = 1'b1;
        cyc("p_br", ex(K_FLS, 2'd0, 1'b0), ex(K_FLS, 2'd0, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("p_w0", ex(K_FRZ, 2'd0, 1'b0), ex(K_FRZ, 2'd0, 1'b0));
        cyc("p_w1", ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        cyc("p_w2", ex(K_FRZ, 2'd2, 1'b0), ex(K_FRZ, 2'd2, 1'b0));
        dmem_ready = 1'b1;
        cyc("p_rel", ex(K_DEF, 2'd2, 1'b0), ex(K_DEF, 2'd2, 1'b0));
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("perf_stall/lus1", sc1, 32'd2);
        check_eq("perf_flush/lus1", fc1, 32'd1);
        check_eq("perf_wait/lus1",  wc1, 32'd3);
        check_eq("perf_stall/lus3", sc3, 32'd6);
        check_eq("perf_flush/lus3", fc3, 32'd1);
        check_eq("perf_wait/lus3",  wc3, 32'd3);
`endif
        cyc("p_end", ex(K_DEF, 2'd0, 1'b0), ex(K_DEF, 2'd0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
